// File: rtl/addec_strobe.sv
// Bus-cycle sequencer behind the address-decode PROM: held read selects, write strobes,
// addressable output latch and vblank watchdog (watchdog present only with ADDEC_WDOG_EN).
module addec_strobe #(
    parameter int WDOG_LIMIT = 8,
    parameter int RESET_LEN  = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       phi2_en,
    input  logic       rw,
    input  logic [3:0] addr_lo,
    input  logic       din0,
    input  logic [7:0] prom_q,
    input  logic       vblank_pulse,
    output logic       ram_cs,
    output logic [7:0] rom_cs,
    output logic       sw_sel,
    output logic       sync_sel,
    output logic       ram_we,
    output logic       steer_rst,
    output logic [7:0] out_latch,
    output logic       cpu_reset
);

    localparam logic [2:0] GRP_NONE  = 3'd0;
    localparam logic [2:0] GRP_RAM   = 3'd1;
    localparam logic [2:0] GRP_SW    = 3'd2;
    localparam logic [2:0] GRP_SYNC  = 3'd3;
    localparam logic [2:0] GRP_LATCH = 3'd4;
    localparam logic [2:0] GRP_WDOG  = 3'd5;
    localparam logic [2:0] GRP_STEER = 3'd6;
    localparam logic [2:0] GRP_ROM   = 3'd7;

    if (WDOG_LIMIT < 1 || WDOG_LIMIT > 15) begin : g_bad_limit
        $error("addec_strobe: WDOG_LIMIT must be 1..15");
    end
    if (RESET_LEN < 1 || RESET_LEN > 255) begin : g_bad_len
        $error("addec_strobe: RESET_LEN must be 1..255");
    end

    logic [2:0] grp_q, grp_d;
    logic [2:0] bank_q, bank_d;
    logic       rw_q, rw_d;
    logic [3:0] addr_q, addr_d;
    logic       din_q, din_d;
    logic       new_q, new_d;

    logic       ram_cs_q, ram_cs_d;
    logic [7:0] rom_cs_q, rom_cs_d;
    logic       sw_sel_q, sw_sel_d;
    logic       sync_sel_q, sync_sel_d;
    logic       ram_we_q, ram_we_d;
    logic       steer_rst_q, steer_rst_d;
    logic [7:0] out_latch_q, out_latch_d;
    logic       wr_s;
    logic       wd_clr_s;

    logic unused_prom_bits;
    assign unused_prom_bits = ^{prom_q[4], prom_q[0]};

    // Cycle register next state: capture the bus cycle on phi2_en, otherwise hold.
    always_comb begin
        grp_d  = grp_q;
        bank_d = bank_q;
        rw_d   = rw_q;
        addr_d = addr_q;
        din_d  = din_q;
        new_d  = phi2_en;
        if (phi2_en) begin
            grp_d  = prom_q[7:5];
            bank_d = prom_q[3:1];
            rw_d   = rw;
            addr_d = addr_lo;
            din_d  = din0;
        end else begin
            new_d  = 1'b0;
        end
    end

    // Decode the captured cycle into held selects and strobes; new_q limits strobes to one clock.
    always_comb begin
        wr_s        = new_q & ~rw_q;
        ram_cs_d    = 1'b0;
        rom_cs_d    = 8'h00;
        sw_sel_d    = 1'b0;
        sync_sel_d  = 1'b0;
        ram_we_d    = 1'b0;
        steer_rst_d = 1'b0;
        wd_clr_s    = 1'b0;
        out_latch_d = out_latch_q;
        case (grp_q)
            GRP_NONE: begin
                ram_cs_d = 1'b0;
            end
            GRP_RAM: begin
                ram_cs_d = 1'b1;
                ram_we_d = wr_s;
            end
            GRP_SW: begin
                sw_sel_d = rw_q;
            end
            GRP_SYNC: begin
                sync_sel_d = rw_q;
            end
            GRP_LATCH: begin
                if (wr_s) begin
                    if (addr_q[3]) begin
                        out_latch_d = 8'h00;
                    end else begin
                        out_latch_d[addr_q[2:0]] = din_q;
                    end
                end else begin
                    out_latch_d = out_latch_q;
                end
            end
            GRP_WDOG: begin
                wd_clr_s = wr_s;
            end
            GRP_STEER: begin
                steer_rst_d = wr_s;
            end
            GRP_ROM: begin
                if (rw_q) begin
                    rom_cs_d = 8'h01 << bank_q;
                end else begin
                    rom_cs_d = 8'h00;
                end
            end
            default: begin
                ram_cs_d = 1'b0;
            end
        endcase
    end

    // Cycle register and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grp_q       <= 3'd0;
            bank_q      <= 3'd0;
            rw_q        <= 1'b0;
            addr_q      <= 4'd0;
            din_q       <= 1'b0;
            new_q       <= 1'b0;
            ram_cs_q    <= 1'b0;
            rom_cs_q    <= 8'h00;
            sw_sel_q    <= 1'b0;
            sync_sel_q  <= 1'b0;
            ram_we_q    <= 1'b0;
            steer_rst_q <= 1'b0;
            out_latch_q <= 8'h00;
        end else begin
            grp_q       <= grp_d;
            bank_q      <= bank_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            new_q       <= new_d;
            ram_cs_q    <= ram_cs_d;
            rom_cs_q    <= rom_cs_d;
            sw_sel_q    <= sw_sel_d;
            sync_sel_q  <= sync_sel_d;
            ram_we_q    <= ram_we_d;
            steer_rst_q <= steer_rst_d;
            out_latch_q <= out_latch_d;
        end
    end

`ifdef ADDEC_WDOG_EN
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] timer_q, timer_d;
    logic       cpu_reset_q, cpu_reset_d;

    // Watchdog: a running timeout freezes the counter and ignores clears and vblank.
    always_comb begin
        cnt_d   = cnt_q;
        timer_d = timer_q;
        if (timer_q != 8'd0) begin
            timer_d = timer_q - 8'd1;
            cnt_d   = 4'd0;
        end else if (wd_clr_s) begin
            cnt_d = 4'd0;
        end else if (vblank_pulse) begin
            if (cnt_q == 4'(WDOG_LIMIT - 1)) begin
                cnt_d   = 4'd0;
                timer_d = 8'(RESET_LEN);
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end else begin
            cnt_d = cnt_q;
        end
        cpu_reset_d = (timer_d != 8'd0);
    end

    // Watchdog state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q       <= 4'd0;
            timer_q     <= 8'd0;
            cpu_reset_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            cpu_reset_q <= cpu_reset_d;
        end
    end

    assign cpu_reset = cpu_reset_q;
`else
    logic unused_wdog;
    assign unused_wdog = ^{vblank_pulse, wd_clr_s};
    assign cpu_reset   = 1'b0;
`endif

    assign ram_cs    = ram_cs_q;
    assign rom_cs    = rom_cs_q;
    assign sw_sel    = sw_sel_q;
    assign sync_sel  = sync_sel_q;
    assign ram_we    = ram_we_q;
    assign steer_rst = steer_rst_q;
    assign out_latch = out_latch_q;

endmodule

// File: tb/tb_addec_strobe.sv
// Bench for addec_strobe: bus-cycle level reference model, directed cases and random stimulus.
module tb_addec_strobe;
    localparam int LIMIT = 8;
    localparam int RLEN  = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       phi2_en;
    logic       rw;
    logic [3:0] addr_lo;
    logic       din0;
    logic [7:0] prom_q;
    logic       vblank_pulse;
    logic       ram_cs, sw_sel, sync_sel, ram_we, steer_rst, cpu_reset;
    logic [7:0] rom_cs, out_latch;

    int errors = 0;
    int checks = 0;

    addec_strobe #(.WDOG_LIMIT(LIMIT), .RESET_LEN(RLEN)) dut (
        .clock(clock), .reset(reset), .phi2_en(phi2_en), .rw(rw), .addr_lo(addr_lo),
        .din0(din0), .prom_q(prom_q), .vblank_pulse(vblank_pulse), .ram_cs(ram_cs),
        .rom_cs(rom_cs), .sw_sel(sw_sel), .sync_sel(sync_sel), .ram_we(ram_we),
        .steer_rst(steer_rst), .out_latch(out_latch), .cpu_reset(cpu_reset)
    );

    always #5 clock = ~clock;

    // Model state: the most recent bus cycle, whether it is fresh, latch and watchdog.
    int         c_grp, c_bank, c_addr;
    logic       c_rw, c_din, c_new;
    logic [7:0] e_latch;
    logic       e_ram_cs, e_sw, e_sync, e_ram_we, e_steer, e_cpu;
    logic [7:0] e_rom;
    int         m_cnt, m_left;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        logic wr;
        if (reset) begin
            c_grp = 0; c_bank = 0; c_addr = 0; c_rw = 1'b0; c_din = 1'b0; c_new = 1'b0;
            e_latch = 8'h00; e_ram_cs = 1'b0; e_sw = 1'b0; e_sync = 1'b0;
            e_ram_we = 1'b0; e_steer = 1'b0; e_cpu = 1'b0; e_rom = 8'h00;
            m_cnt = 0; m_left = 0;
            return;
        end
        e_ram_cs = (c_grp == 1);
        e_rom    = (c_grp == 7 && c_rw) ? (8'h01 << c_bank) : 8'h00;
        e_sw     = (c_grp == 2 && c_rw);
        e_sync   = (c_grp == 3 && c_rw);
        wr       = c_new && !c_rw;
        e_ram_we = wr && c_grp == 1;
        e_steer  = wr && c_grp == 6;
        if (wr && c_grp == 4) begin
            if (c_addr >= 8) e_latch = 8'h00;
            else e_latch[c_addr] = c_din;
        end
`ifdef ADDEC_WDOG_EN
        if (m_left > 0) m_left--;
        else if (wr && c_grp == 5) m_cnt = 0;
        else if (vblank_pulse) begin
            m_cnt++;
            if (m_cnt == LIMIT) begin
                m_cnt  = 0;
                m_left = RLEN;
            end
        end
        e_cpu = (m_left > 0);
`else
        e_cpu = 1'b0;
`endif
        c_new = phi2_en;
        if (phi2_en) begin
            c_grp  = int'(prom_q[7:5]);
            c_bank = int'(prom_q[3:1]);
            c_rw   = rw;
            c_addr = int'(addr_lo);
            c_din  = din0;
        end
    endtask

    always @(posedge clock or posedge reset) model_step();

    // Compare process: every falling edge outside reset.
    always @(negedge clock) begin
        if (!reset) begin
            chk("ram_cs", {7'd0, ram_cs}, {7'd0, e_ram_cs});
            chk("rom_cs", rom_cs, e_rom);
            chk("sw_sel", {7'd0, sw_sel}, {7'd0, e_sw});
            chk("sync_sel", {7'd0, sync_sel}, {7'd0, e_sync});
            chk("ram_we", {7'd0, ram_we}, {7'd0, e_ram_we});
            chk("steer_rst", {7'd0, steer_rst}, {7'd0, e_steer});
            chk("out_latch", out_latch, e_latch);
            chk("cpu_reset", {7'd0, cpu_reset}, {7'd0, e_cpu});
        end
    end

    // Apply one clock of inputs; returns just after the following falling edge.
    task automatic go(input logic p, input logic [7:0] pq, input logic r,
                      input logic [3:0] a, input logic d, input logic vb);
        phi2_en = p; prom_q = pq; rw = r; addr_lo = a; din0 = d; vblank_pulse = vb;
        @(negedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        phi2_en = 1'b1;
        #1;
        chk("rst_ram_cs", {7'd0, ram_cs}, 8'h00);
        chk("rst_rom_cs", rom_cs, 8'h00);
        chk("rst_sel", {6'd0, sw_sel, sync_sel}, 8'h00);
        chk("rst_strobes", {6'd0, ram_we, steer_rst}, 8'h00);
        chk("rst_out_latch", out_latch, 8'h00);
        chk("rst_cpu_reset", {7'd0, cpu_reset}, 8'h00);
        @(negedge clock);
        #1;
        reset = 1'b0;
        phi2_en = 1'b0;
    endtask

    int hi;

    initial begin
        reset = 1'b1; phi2_en = 1'b1; rw = 1'b1; addr_lo = 4'd0; din0 = 1'b0;
        prom_q = 8'hEA; vblank_pulse = 1'b0;
        @(negedge clock);
        #1;
        do_reset();

        // ROM read: group 7, bank 5
        go(1'b1, 8'hEA, 1'b1, 4'd0, 1'b0, 1'b0);
        go(1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("rom_read", rom_cs, 8'h20);
        go(1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("rom_held", rom_cs, 8'h20);
        chk("rom_no_we", {7'd0, ram_we}, 8'h00);

        // RAM write: select held, single-clock strobe
        go(1'b1, 8'h20, 1'b0, 4'd0, 1'b0, 1'b0);
        go(1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0);
        chk("ram_we_pulse", {6'd0, ram_cs, ram_we}, 8'h03);
        go(1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0);
        chk("ram_we_drop", {6'd0, ram_cs, ram_we}, 8'h02);

        // Output latch, back-to-back writes
        go(1'b1, 8'h80, 1'b0, 4'd3, 1'b1, 1'b0);
        go(1'b1, 8'h80, 1'b0, 4'd6, 1'b1, 1'b0);
        go(1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0);
        chk("latch_set", out_latch, 8'h48);
        go(1'b1, 8'h80, 1'b1, 4'd3, 1'b0, 1'b0);
        go(1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0);
        go(1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0);
        chk("latch_read", out_latch, 8'h48);
        go(1'b1, 8'h80, 1'b0, 4'd8, 1'b0, 1'b0);
        go(1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0);
        chk("latch_clear", out_latch, 8'h00);

        // Pending RAM write killed by asynchronous reset
        go(1'b1, 8'h20, 1'b0, 4'd0, 1'b0, 1'b0);
        do_reset();
        go(1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0);
        chk("no_strobe_after_rst", {7'd0, ram_we}, 8'h00);

`ifdef ADDEC_WDOG_EN
        hi = 0;
        for (int i = 0; i < LIMIT; i++) begin
            go(1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b1);
            if (cpu_reset) hi++;
            go(1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0);
            if (cpu_reset) hi++;
        end
        for (int i = 0; i < 40; i++) begin
            go(1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0);
            if (cpu_reset) hi++;
        end
        chk("wdog_len", 8'(hi), 8'd16);

        // Clear coinciding with the 7th pulse
        hi = 0;
        for (int i = 0; i < 6; i++) begin
            go(1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b1);
            go(1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0);
        end
        go(1'b1, 8'hA0, 1'b0, 4'd0, 1'b0, 1'b0);
        go(1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            go(1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b1);
            if (cpu_reset) hi++;
            go(1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0);
            if (cpu_reset) hi++;
        end
        chk("wdog_cleared", 8'(hi), 8'd0);

        // One more pulse times out; reset mid-timeout drops cpu_reset at once
        go(1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b1);
        go(1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0);
        chk("wdog_fire", {7'd0, cpu_reset}, 8'h01);
        do_reset();
`else
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            go(1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b1);
            if (cpu_reset) hi++;
            go(1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0);
            if (cpu_reset) hi++;
        end
        chk("no_wdog", 8'(hi), 8'd0);
`endif

        // Random bus traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            go(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 5) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
